// File: rtl/gx4000_asic_unlock_seq.sv
// Plus/GX4000 ASIC unlock sequence detector: snoops CRTC-select port writes, tracks the
// sync/sequence protocol and drives asic_unlocked, event strobes, attempt count and status readback.
module gx4000_asic_unlock_seq #(
    parameter int                   SEQ_LEN    = 17,
    parameter logic [SEQ_LEN*8-1:0] SEQ        = 136'hFF00FF77B351A8D462399C462B158ACDEE,
    parameter int                   UNLOCK_IDX = 15,
    parameter logic [15:0]          ADDR_VAL   = 16'hBC00,
    parameter logic [15:0]          ADDR_MSK   = 16'hFF00,
    parameter logic [15:0]          STAT_ADDR  = 16'hBCFF,
    parameter int                   TIMEOUT    = 0,
    parameter int                   TO_W       = 16,
    parameter int                   CNT_W      = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             plus_mode,
    input  logic [15:0]      cpu_addr,
    input  logic [7:0]       cpu_data_in,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    output logic [7:0]       cpu_data_out,
    output logic             asic_unlocked,
    output logic [4:0]       seq_step,
    output logic             unlock_pulse,
    output logic             lock_pulse,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] attempt_cnt
);

    // MATCH is encoded as 2'b00 so that status reads taken mid-sequence carry a zero state field.
    typedef enum logic [1:0] {
        ST_MATCH = 2'b00,
        ST_HUNT  = 2'b01,
        ST_ARMED = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [4:0]       LAST_STEP   = 5'(SEQ_LEN - 1);
    localparam logic [4:0]       UNLOCK_STEP = 5'(UNLOCK_IDX);
    localparam logic             TO_EN       = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]  TO_LIMIT    = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_MAX      = {TO_W{1'b1}};
    localparam logic [TO_W-1:0]  TO_ONE      = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  TO_ZERO     = {TO_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    if ((SEQ_LEN < 1) || (SEQ_LEN > 32)) begin : g_bad_seq_len
        $error("gx4000_asic_unlock_seq: SEQ_LEN must be within 1..32");
    end
    if ((UNLOCK_IDX < 0) || (UNLOCK_IDX >= SEQ_LEN)) begin : g_bad_unlock_idx
        $error("gx4000_asic_unlock_seq: UNLOCK_IDX must be below SEQ_LEN");
    end

    // Sequence table padded to 32 entries so a 5-bit step always indexes in range.
    logic [7:0] seq_arr_s [32];
    for (genvar gi = 0; gi < 32; gi++) begin : g_seq
        if (gi < SEQ_LEN) begin : g_used
            assign seq_arr_s[gi] = SEQ[(SEQ_LEN-1-gi)*8 +: 8];
        end else begin : g_pad
            assign seq_arr_s[gi] = 8'h00;
        end
    end

    state_t           state_r, state_nxt_s;
    logic [4:0]       step_r, step_nxt_s;
    logic             prev_nz_r, prev_nz_nxt_s;
    logic             unlocked_r, unlocked_nxt_s;
    logic             unlock_pulse_r, unlock_pulse_nxt_s;
    logic             lock_pulse_r, lock_pulse_nxt_s;
    logic             timeout_pulse_r, timeout_pulse_nxt_s;
    logic [CNT_W-1:0] attempt_r, attempt_nxt_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_nxt_s;
    logic             wr_q_r;
    logic [7:0]       dout_r, dout_nxt_s;

    logic             addr_hit_s;
    logic             accept_s;
    logic             stat_sel_s;
    logic             data_nz_s;
    logic             byte_ok_s;
    logic             at_unlock_s;
    logic             at_last_s;
    logic [4:0]       step_inc_s;
    logic [CNT_W-1:0] att_inc_s;
    logic [TO_W-1:0]  to_inc_s;
    logic             to_hit_s;

    // A long strobe is accepted only on its first cycle.
    assign addr_hit_s  = ((cpu_addr & ADDR_MSK) == ADDR_VAL);
    assign accept_s    = cpu_wr & ~wr_q_r & addr_hit_s & plus_mode;
    assign stat_sel_s  = cpu_rd & (cpu_addr == STAT_ADDR) & plus_mode;
    assign data_nz_s   = (cpu_data_in != 8'h00);
    assign byte_ok_s   = (cpu_data_in == seq_arr_s[step_r]);
    assign at_unlock_s = (step_r == UNLOCK_STEP);
    assign at_last_s   = (step_r == LAST_STEP);
    assign step_inc_s  = step_r + 5'd1;
    assign att_inc_s   = (attempt_r == CNT_MAX) ? attempt_r : (attempt_r + CNT_ONE);
    assign to_inc_s    = (to_cnt_r == TO_MAX) ? to_cnt_r : (to_cnt_r + TO_ONE);
    assign to_hit_s    = TO_EN & (to_inc_s >= TO_LIMIT);
    assign dout_nxt_s  = stat_sel_s ? {unlocked_r, state_r, step_r} : 8'h00;

    // Next-state, lock decision, counters and event strobes.
    always_comb begin
        state_nxt_s         = state_r;
        step_nxt_s          = step_r;
        prev_nz_nxt_s       = prev_nz_r;
        unlocked_nxt_s      = unlocked_r;
        attempt_nxt_s       = attempt_r;
        to_cnt_nxt_s        = to_cnt_r;
        unlock_pulse_nxt_s  = 1'b0;
        lock_pulse_nxt_s    = 1'b0;
        timeout_pulse_nxt_s = 1'b0;
        if (!plus_mode) begin
            state_nxt_s    = ST_HUNT;
            step_nxt_s     = 5'd0;
            unlocked_nxt_s = 1'b0;
            to_cnt_nxt_s   = TO_ZERO;
        end else if (accept_s) begin
            prev_nz_nxt_s = data_nz_s;
            to_cnt_nxt_s  = TO_ZERO;
            case (state_r)
                ST_HUNT: begin
                    if (data_nz_s) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_ARMED: begin
                    if (!data_nz_s) begin
                        state_nxt_s   = ST_MATCH;
                        step_nxt_s    = 5'd0;
                        attempt_nxt_s = att_inc_s;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_MATCH: begin
                    if (byte_ok_s) begin
                        if (at_unlock_s) begin
                            unlocked_nxt_s     = 1'b1;
                            unlock_pulse_nxt_s = ~unlocked_r;
                        end else begin
                            unlocked_nxt_s = unlocked_r;
                        end
                        if (at_last_s) begin
                            state_nxt_s = ST_DONE;
                            step_nxt_s  = 5'd0;
                        end else begin
                            step_nxt_s = step_inc_s;
                        end
                    end else begin
                        if (at_unlock_s) begin
                            unlocked_nxt_s   = 1'b0;
                            lock_pulse_nxt_s = unlocked_r;
                        end else begin
                            unlocked_nxt_s = unlocked_r;
                        end
                        step_nxt_s = 5'd0;
                        // A zero right after a nonzero byte is a fresh sync, not just an error.
                        if (!data_nz_s && prev_nz_r) begin
                            state_nxt_s   = ST_MATCH;
                            attempt_nxt_s = att_inc_s;
                        end else if (data_nz_s) begin
                            state_nxt_s = ST_ARMED;
                        end else begin
                            state_nxt_s = ST_HUNT;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt_s = prev_nz_r ? ST_ARMED : ST_HUNT;
                    step_nxt_s  = 5'd0;
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                    step_nxt_s  = 5'd0;
                end
            endcase
        end else begin
            case (state_r)
                ST_DONE: begin
                    state_nxt_s  = prev_nz_r ? ST_ARMED : ST_HUNT;
                    step_nxt_s   = 5'd0;
                    to_cnt_nxt_s = TO_ZERO;
                end
                ST_ARMED, ST_MATCH: begin
                    if (to_hit_s) begin
                        state_nxt_s         = ST_HUNT;
                        step_nxt_s          = 5'd0;
                        timeout_pulse_nxt_s = 1'b1;
                        to_cnt_nxt_s        = TO_ZERO;
                    end else begin
                        to_cnt_nxt_s = to_inc_s;
                    end
                end
                ST_HUNT: begin
                    to_cnt_nxt_s = TO_ZERO;
                end
                default: begin
                    state_nxt_s  = ST_HUNT;
                    step_nxt_s   = 5'd0;
                    to_cnt_nxt_s = TO_ZERO;
                end
            endcase
        end
    end

    // State, counters, strobes and readback registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_HUNT;
            step_r          <= 5'd0;
            prev_nz_r       <= 1'b0;
            unlocked_r      <= 1'b0;
            unlock_pulse_r  <= 1'b0;
            lock_pulse_r    <= 1'b0;
            timeout_pulse_r <= 1'b0;
            attempt_r       <= CNT_ZERO;
            to_cnt_r        <= TO_ZERO;
            wr_q_r          <= 1'b0;
            dout_r          <= 8'h00;
        end else begin
            state_r         <= state_nxt_s;
            step_r          <= step_nxt_s;
            prev_nz_r       <= prev_nz_nxt_s;
            unlocked_r      <= unlocked_nxt_s;
            unlock_pulse_r  <= unlock_pulse_nxt_s;
            lock_pulse_r    <= lock_pulse_nxt_s;
            timeout_pulse_r <= timeout_pulse_nxt_s;
            attempt_r       <= attempt_nxt_s;
            to_cnt_r        <= to_cnt_nxt_s;
            wr_q_r          <= cpu_wr;
            dout_r          <= dout_nxt_s;
        end
    end

    assign cpu_data_out  = dout_r;
    assign asic_unlocked = unlocked_r;
    assign seq_step      = step_r;
    assign unlock_pulse  = unlock_pulse_r;
    assign lock_pulse    = lock_pulse_r;
    assign timeout_pulse = timeout_pulse_r;
    assign attempt_cnt   = attempt_r;

endmodule

// File: tb/tb_gx4000_asic_unlock_seq.sv
// Scoreboard bench for gx4000_asic_unlock_seq: a protocol-level reference model predicts every
// clock's outputs, a negedge monitor pops and compares them.
module tb_gx4000_asic_unlock_seq;

    localparam int TO   = 100;
    localparam int UIDX = 15;
    localparam logic [7:0] SEQB [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
                                         8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};
    localparam int PH_HUNT = 0, PH_ARMED = 1, PH_MATCH = 2, PH_DONE = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        plus_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_data_out;
    logic        asic_unlocked;
    logic [4:0]  seq_step;
    logic        unlock_pulse, lock_pulse, timeout_pulse;
    logic [15:0] attempt_cnt;

    gx4000_asic_unlock_seq #(.TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_data_out(cpu_data_out), .asic_unlocked(asic_unlocked), .seq_step(seq_step),
        .unlock_pulse(unlock_pulse), .lock_pulse(lock_pulse), .timeout_pulse(timeout_pulse),
        .attempt_cnt(attempt_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        unl;
        logic [4:0]  step;
        logic [2:0]  pul;
        logic [15:0] att;
        logic [7:0]  dout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // protocol-level model state
    int m_ph, m_step, m_att, m_idle;
    bit m_unl, m_prevnz, m_wrq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] ph_code(input int ph);
        case (ph)
            PH_MATCH: return 2'b00;
            PH_HUNT:  return 2'b01;
            PH_ARMED: return 2'b10;
            default:  return 2'b11;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = PH_HUNT; m_step = 0; m_att = 0; m_idle = 0;
        m_unl = 1'b0; m_prevnz = 1'b0; m_wrq = 1'b0;
    endtask

    task automatic bump_attempt();
        if (m_att < 65535) m_att++;
    endtask

    // What the block must show after the coming clock edge, given the inputs now applied.
    task automatic model_edge(output exp_t e);
        bit         acc, rsel, nz;
        logic [2:0] pul;
        logic [7:0] d;
        pul  = 3'b000;
        d    = cpu_data_in;
        nz   = (d != 8'h00);
        acc  = cpu_wr && !m_wrq && (cpu_addr[15:8] == 8'hBC) && plus_mode;
        rsel = cpu_rd && (cpu_addr == 16'hBCFF) && plus_mode;
        e.dout = rsel ? {m_unl, ph_code(m_ph), 5'(m_step)} : 8'h00;
        m_wrq = cpu_wr;
        if (!plus_mode) begin
            m_ph = PH_HUNT; m_step = 0; m_unl = 1'b0; m_idle = 0;
        end else if (acc) begin
            m_idle = 0;
            if (m_ph == PH_HUNT) begin
                if (nz) m_ph = PH_ARMED;
            end else if (m_ph == PH_ARMED) begin
                if (!nz) begin m_ph = PH_MATCH; m_step = 0; bump_attempt(); end
            end else if (m_ph == PH_MATCH) begin
                if (d == SEQB[m_step]) begin
                    if (m_step == UIDX && !m_unl) begin m_unl = 1'b1; pul[2] = 1'b1; end
                    if (m_step == 16) begin m_ph = PH_DONE; m_step = 0; end
                    else m_step++;
                end else begin
                    if (m_step == UIDX && m_unl) begin m_unl = 1'b0; pul[1] = 1'b1; end
                    m_step = 0;
                    if (!nz && m_prevnz) bump_attempt();
                    else m_ph = nz ? PH_ARMED : PH_HUNT;
                end
            end
            m_prevnz = nz;
        end else if (m_ph == PH_DONE) begin
            m_ph = m_prevnz ? PH_ARMED : PH_HUNT;
        end else if (m_ph != PH_HUNT) begin
            m_idle++;
            if (m_idle >= TO) begin m_ph = PH_HUNT; m_step = 0; pul[0] = 1'b1; m_idle = 0; end
        end
        e.unl  = m_unl;
        e.step = 5'(m_step);
        e.pul  = pul;
        e.att  = 16'(m_att);
    endtask

    task automatic step_clk();
        exp_t e;
        model_edge(e);
        @(posedge clk_sys);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold);
        cpu_addr = a; cpu_data_in = d; cpu_wr = 1'b1;
        repeat (hold) step_clk();
        cpu_wr = 1'b0;
        step_clk();
    endtask

    task automatic wrb(input logic [7:0] d);
        wr(16'hBC00, d, 1);
    endtask

    task automatic send_seq(input int from, input int upto);
        for (int i = from; i <= upto; i++) wrb(SEQB[i]);
    endtask

    task automatic rd(input logic [15:0] a);
        cpu_addr = a; cpu_rd = 1'b1;
        step_clk();
        cpu_rd = 1'b0;
        step_clk();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, cpu_data_out, 8'h00);
        check({tag, "_unlocked"}, asic_unlocked, 1'b0);
        check({tag, "_step"}, seq_step, 5'd0);
        check({tag, "_pulses"}, {unlock_pulse, lock_pulse, timeout_pulse}, 3'b000);
        check({tag, "_attempt"}, attempt_cnt, 16'h0000);
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset();
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk_sys) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("unlocked", asic_unlocked, mon_e.unl);
            check("seq_step", seq_step, mon_e.step);
            check("pulses", {unlock_pulse, lock_pulse, timeout_pulse}, mon_e.pul);
            check("attempt_cnt", attempt_cnt, mon_e.att);
            check("data_out", cpu_data_out, mon_e.dout);
        end
    end

    initial begin
        int          r;
        logic [7:0]  d;
        logic [15:0] a;
        reset_n = 1'b0; plus_mode = 1'b1; cpu_addr = 16'h0000; cpu_data_in = 8'h00;
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // full default unlock
        wrb(8'h01); wrb(8'h00); send_seq(0, 16);
        check("unlocked_after_seq", asic_unlocked, 1'b1);

        // status read mid-sequence at step 4, then relock on CC
        wrb(8'h00); send_seq(0, 3);
        cpu_addr = 16'hBCFF; cpu_rd = 1'b1;
        step_clk();
        check("readback_step4", cpu_data_out, 8'h84);
        cpu_rd = 1'b0;
        step_clk();
        send_seq(4, 14); wrb(8'hCC);
        check("locked_after_cc", asic_unlocked, 1'b0);

        // relock then wrong byte at step 3 leaves the unlock alone
        wrb(8'h00); send_seq(0, 16);
        wrb(8'h00); send_seq(0, 2); wrb(8'h12);
        check("unlocked_after_step3_err", asic_unlocked, 1'b1);

        // long strobe is a single accept
        wrb(8'h00);
        wr(16'hBC00, 8'hFF, 4);
        check("long_strobe_step", seq_step, 5'd1);

        // resync via 05,00 and fall to HUNT on 00 after 00
        send_seq(1, 4); wrb(8'h05); wrb(8'h00);
        check("resync_step", seq_step, 5'd0);
        wrb(8'h00);
        rd(16'hBCFF);

        // idle timeout after step 6
        wrb(8'h01); wrb(8'h00); send_seq(0, 5);
        repeat (TO) step_clk();
        check("timeout_step", seq_step, 5'd0);
        check("timeout_keeps_unlock", asic_unlocked, 1'b1);
        rd(16'hBCFF);

        // address masking and plus_mode gating
        wr(16'hBD00, 8'h01, 1); wr(16'hBC7F, 8'h01, 1); wrb(8'h00); send_seq(0, 2);
        plus_mode = 1'b0;
        step_clk(); wrb(8'hFF); rd(16'hBCFF);
        plus_mode = 1'b1;
        step_clk();

        // async reset in the middle of an unlocked sequence
        wrb(8'h01); wrb(8'h00); send_seq(0, 16); wrb(8'h00); send_seq(0, 3);
        async_reset();

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                d = (m_ph == PH_MATCH && $urandom_range(0, 2) != 0) ? SEQB[m_step] : 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
                a = ($urandom_range(0, 9) == 0) ? 16'h7F00 : {8'hBC, 8'($urandom)};
                wr(a, d, $urandom_range(1, 3));
                repeat ($urandom_range(0, 2)) step_clk();
            end else if (r < 65) begin
                if (m_ph != PH_MATCH) begin wrb(8'h01); wrb(8'h00); end
                for (int k = m_step; k <= 16; k++) wrb((k == UIDX && $urandom_range(0, 3) == 0) ? 8'hCC : SEQB[k]);
            end else if (r < 78) begin
                rd(($urandom_range(0, 3) == 0) ? 16'hBCFE : 16'hBCFF);
            end else if (r < 83) begin
                repeat ($urandom_range(60, 110)) step_clk();
            end else if (r < 87) begin
                plus_mode = 1'b0;
                repeat ($urandom_range(1, 3)) step_clk();
                wrb(8'($urandom));
                plus_mode = 1'b1;
                step_clk();
            end else if (r < 89) begin
                async_reset();
            end else begin
                step_clk();
            end
        end

        repeat (3) step_clk();
        @(negedge clk_sys);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
